spi_byte_tx: RTL
================

# spi_byte_tx

Serial transmit stage for the ILI9341 display path. It sits directly downstream of the command sequencer: it accepts one byte plus its D/C and CS qualifiers on a send request, and shifts the byte out MSB-first in SPI mode 0 with a programmable SCLK rate. It returns a one-cycle completion pulse that advances the sequencer's command counter.

## Interface
Parameters:
- DW, 8: byte width shifted per transfer.
- CLK_DIV, 2: system clocks per SCLK half-period; legal range ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- i_send  in  1  transfer request. Sampled only in IDLE. Upstream may hold it high until o_sent.
- i_data  in  DW  byte to transmit. Latched on accept.
- i_dc  in  1  data/command select. Latched on accept.
- i_cs  in  1  chip-select level for this byte, active-low. Latched on accept.
- o_sent  out  1  one-cycle pulse at end of transfer. Drives the sequencer's command-sent input.
- o_busy  out  1  high whenever state ≠ IDLE.
- o_sclk  out  1  SPI clock. Idles low.
- o_mosi  out  1  serial data, MSB first.
- o_dc  out  1  latched D/C to the panel.
- o_cs  out  1  panel chip select.

## Operation
- States: IDLE, SHIFT_L, SHIFT_H, HOLD, DONE.
- Counters:
  - Divider counter: width $clog2(CLK_DIV+1). Counts CLK_DIV cycles per phase.
  - Bit counter: width $clog2(DW+1). Counts down DW..1.
- IDLE:
  - On i_send=1: latch i_data into the shift register, latch i_dc and i_cs, load bit counter = DW, go to SHIFT_L.
  - Otherwise stay in IDLE.
- SHIFT_L:
  - o_sclk=0, o_mosi = current MSB of the shift register.
  - After CLK_DIV cycles, go to SHIFT_H.
- SHIFT_H:
  - o_sclk=1, o_mosi held. The panel samples on this rising edge.
  - After CLK_DIV cycles, decrement the bit counter.
  - If the counter was 1, go to HOLD. Otherwise shift left by one and go to SHIFT_L.
- HOLD:
  - o_sclk=0, o_mosi holds bit 0, CS stays at the latched level.
  - Lasts CLK_DIV cycles, then go to DONE.
- DONE:
  - o_sent=1 for exactly one cycle, then go to IDLE.
- o_cs:
  - HIGH in IDLE.
  - Equals the latched i_cs from SHIFT_L through DONE.
  - A transfer latched with i_cs=1 still clocks all DW bits, with the panel deselected.
- o_dc: equals the latched value from SHIFT_L onward. Retained in IDLE until the next accept.
- o_mosi: 0 in IDLE.
- i_send while busy: ignored, with no queuing. i_data, i_dc and i_cs changes while busy have no effect.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset values: o_sclk=0, o_mosi=0, o_cs=1, o_dc=1, o_sent=0, o_busy=0, state=IDLE.
- Reset mid-transfer: outputs take reset values immediately and asynchronously. No o_sent is produced, and the partial byte is discarded.
- Let T0 be the IDLE cycle in which i_send=1 is sampled.
  - T0+1: o_busy=1, o_cs=latched level, o_mosi=i_data[DW-1].
  - Bit k (k=0 for the MSB): low phase starts at T0+1+2·k·CLK_DIV; high phase starts at T0+1+(2k+1)·CLK_DIV.
  - o_sent is high in cycle T0+1+(2·DW+1)·CLK_DIV. For DW=8, CLK_DIV=2 that is T0+35.
  - o_busy drops the cycle after o_sent.
- Earliest next accept: the cycle after o_sent. Back-to-back transfers have a one-cycle IDLE gap with o_cs=1.
- SCLK period is 2·CLK_DIV cycles with 50% duty.
- With CLK_DIV=1: each half-period is 1 cycle, and o_sent is at T0+2·DW+2.
- Compatibility with the sequencer holding i_send high:
  - In the o_sent cycle the sequencer leaves its COMMAND state, so i_send is low in the following IDLE cycle.
  - A request still high in that cycle is accepted as a new transfer.

## Test plan
- Reset checks:
  - After reset, check all six output reset values.
  - Assert rst low at T0+10 of an active transfer → outputs return to reset values in the same cycle, no o_sent pulse, o_busy=0.
- DW=8, CLK_DIV=2, i_data=0xA5, i_dc=0, i_cs=0, single i_send pulse → sample o_mosi on 8 rising o_sclk edges and expect 1,0,1,0,0,1,0,1. Expect o_cs=0 and o_dc=0 throughout, and o_sent only at T0+35.
- i_send held high from T0 through o_sent → exactly one transfer. Dropping i_send at o_sent yields no second transfer.
- Two requests with 0x2A/dc=0 then 0x00/dc=1 → second accepted one cycle after the first o_sent. o_cs=1 for exactly one cycle between them, and o_dc switches to 1 at the second transfer start.
- CLK_DIV=1, i_data=0xFF, i_cs=1 → 8 SCLK pulses of period 2. o_cs stays 1 and o_sent is at T0+18.
- Change i_data and toggle i_send while o_busy=1 → the shifted byte equals the originally latched value, and no extra o_sent occurs.

Source files
------------

// File: rtl/spi_byte_tx_if.sv
// Byte request/response handshake plus panel pins for spi_byte_tx.
// master = command sequencer side, slave = the transmit stage.
interface spi_byte_tx_if #(
   parameter int DW = 8
);
   logic          i_send;
   logic [DW-1:0] i_data;
   logic          i_dc;
   logic          i_cs;
   logic          o_sent;
   logic          o_busy;
   logic          o_sclk;
   logic          o_mosi;
   logic          o_dc;
   logic          o_cs;

   modport master (
      output i_send, i_data, i_dc, i_cs,
      input  o_sent, o_busy, o_sclk, o_mosi, o_dc, o_cs
   );

   modport slave (
      input  i_send, i_data, i_dc, i_cs,
      output o_sent, o_busy, o_sclk, o_mosi, o_dc, o_cs
   );
endinterface

// File: rtl/spi_byte_tx.sv
// Mode-0 SPI byte serializer for the ILI9341 path: shifts one latched byte
// MSB-first at a programmable SCLK rate and pulses o_sent when finished.
module spi_byte_tx #(
   parameter int DW      = 8,
   parameter int CLK_DIV = 2
) (
   input logic          clk,
   input logic          rst,
   spi_byte_tx_if.slave bus
);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = $clog2(DW + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DW);

   typedef enum logic [2:0] {IDLE, SHIFT_L, SHIFT_H, HOLD, DONE} state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q,   div_d;
   logic [BIT_W-1:0] bit_q,   bit_d;
   logic [DW-1:0]    shreg_q, shreg_d;
   logic             dc_q,    dc_d;
   logic             cs_q,    cs_d;
   logic             sclk_q,  sclk_d;
   logic             mosi_q,  mosi_d;
   logic             sent_q,  sent_d;
   logic             busy_q,  busy_d;
   logic             phase_end;

   assign phase_end = (div_q == DIV_LAST);

   always_comb begin
      // NOTE: every target gets a default first, so no path can infer a latch.
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      dc_d    = dc_q;
      cs_d    = cs_q;

      case (state_q)
         IDLE: begin
            if (bus.i_send) begin
               shreg_d = bus.i_data;
               dc_d    = bus.i_dc;
               cs_d    = bus.i_cs;
               bit_d   = BIT_LOAD;
               div_d   = '0;
               state_d = SHIFT_L;
            end
         end
         SHIFT_L: begin
            div_d = phase_end ? '0 : div_q + DIV_W'(1);
            if (phase_end) state_d = SHIFT_H;
         end
         SHIFT_H: begin
            div_d = phase_end ? '0 : div_q + DIV_W'(1);
            if (phase_end) begin
               bit_d = bit_q - BIT_W'(1);
               if (bit_q == BIT_W'(1)) begin
                  state_d = HOLD;
               end else begin
                  shreg_d = {shreg_q[DW-2:0], 1'b0};
                  state_d = SHIFT_L;
               end
            end
         end
         HOLD: begin
            div_d = phase_end ? '0 : div_q + DIV_W'(1);
            if (phase_end) state_d = DONE;
         end
         DONE: begin
            cs_d    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Pin values are decoded from the next state so every output is a flop.
      sclk_d = (state_d == SHIFT_H);
      mosi_d = (state_d inside {SHIFT_L, SHIFT_H, HOLD}) ? shreg_d[DW-1] : 1'b0;
      sent_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         dc_q    <= 1'b1;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         sent_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         dc_q    <= dc_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         sent_q  <= sent_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.o_sclk = sclk_q;
   assign bus.o_mosi = mosi_q;
   assign bus.o_dc   = dc_q;
   assign bus.o_cs   = cs_q;
   assign bus.o_sent = sent_q;
   assign bus.o_busy = busy_q;
endmodule
